// File: rtl/pci_arb_if.sv
// Bus-side signal bundle between the PCI arbiter (master modport) and the
// requesting devices / bus monitor (slave modport).
interface pci_arb_if #(
  parameter int NUM_DEV = 3,
  parameter int IDX_W   = $clog2(NUM_DEV)
);
  logic [NUM_DEV-1:0] req_n;
  logic               frame_n;
  logic               irdy_n;
  logic [NUM_DEV-1:0] gnt_n;
  logic [IDX_W-1:0]   owner;
  logic               owner_valid;
  logic               timeout;

  modport master (
    input  req_n, frame_n, irdy_n,
    output gnt_n, owner, owner_valid, timeout
  );

  modport slave (
    output req_n, frame_n, irdy_n,
    input  gnt_n, owner, owner_valid, timeout
  );
endinterface

// File: rtl/pci_arbiter.sv
// Round-robin PCI bus arbiter with one dead turnaround cycle between owners
// and grant reclaim on missing FRAME. Define PCI_ARB_PARK_EN to park the bus.
//
// state   | meaning
// IDLE    | no owner; arbitrate pending requests (or park)
// GRANTED | grant issued, waiting for FRAME, request drop or timeout
// BUSY    | transaction in progress, grant held until bus idle
// TURN    | one dead cycle with all grants high, then arbitrate again
module pci_arbiter #(
  parameter int NUM_DEV = 3,
  parameter int TIMEOUT = 16,
  parameter int IDX_W   = $clog2(NUM_DEV)
) (
  input  logic      clk,
  input  logic      reset,
  pci_arb_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_GRANTED, S_BUSY, S_TURN} state_t;

  localparam logic [7:0]         TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   LAST_DEV = IDX_W'(NUM_DEV - 1);
  localparam logic [NUM_DEV-1:0] ALL_OFF  = '1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [7:0]         timer_q, timer_d;
  logic [NUM_DEV-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;

  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   idx_v;
  logic               any_req;
  logic [IDX_W-1:0]   owner_inc;
  logic               arb;

  function automatic logic [NUM_DEV-1:0] grant_mask(input logic [IDX_W-1:0] idx);
    grant_mask = ~(NUM_DEV'(1) << idx);
  endfunction

  assign owner_inc = (owner_q == LAST_DEV) ? '0 : owner_q + 1'b1;

`ifdef PCI_ARB_PARK_EN
  logic parked;
  assign parked = (state_q == S_IDLE) && !gnt_q[owner_q];
`endif

  // First active requester scanning from ptr upward, wrapping at NUM_DEV.
  always_comb begin
    win     = ptr_q;
    any_req = 1'b0;
    idx_v   = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      idx_v = IDX_W'((int'(ptr_q) + k) % NUM_DEV);
      if (!any_req && !bus.req_n[idx_v]) begin
        win     = idx_v;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    timer_d   = timer_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    arb       = 1'b0;

    unique case (state_q)
      S_IDLE: arb = 1'b1;
      S_GRANTED: begin
        if (!bus.frame_n) begin
          state_d = S_BUSY;
          ptr_d   = owner_inc;
        end else if (bus.req_n[owner_q]) begin
          state_d = S_TURN;
          gnt_d   = ALL_OFF;
          valid_d = 1'b0;
        end else if (timer_q == TO_LAST) begin
          state_d   = S_TURN;
          gnt_d     = ALL_OFF;
          valid_d   = 1'b0;
          timeout_d = 1'b1;
          ptr_d     = owner_inc;
        end else if (timer_q != 8'hFF) begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_BUSY: begin
        if (bus.frame_n && bus.irdy_n) begin
          state_d = S_TURN;
          gnt_d   = ALL_OFF;
          valid_d = 1'b0;
        end
      end
      S_TURN: arb = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // TURN arbitrates like IDLE so the next grant lands right after the dead cycle.
    if (arb) begin
`ifdef PCI_ARB_PARK_EN
      if (any_req && parked && (win != owner_q)) begin
        state_d = S_TURN;
        gnt_d   = ALL_OFF;
        valid_d = 1'b0;
      end else if (any_req) begin
        state_d = S_GRANTED;
        gnt_d   = grant_mask(win);
        owner_d = win;
        valid_d = 1'b1;
        timer_d = '0;
      end else if (parked && !bus.frame_n) begin
        state_d = S_BUSY;
      end else begin
        state_d = S_IDLE;
        gnt_d   = grant_mask(owner_q);
        valid_d = 1'b0;
      end
`else
      if (any_req) begin
        state_d = S_GRANTED;
        gnt_d   = grant_mask(win);
        owner_d = win;
        valid_d = 1'b1;
        timer_d = '0;
      end else begin
        state_d = S_IDLE;
        gnt_d   = ALL_OFF;
        valid_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      timer_q   <= '0;
      gnt_q     <= ALL_OFF;
      owner_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt_n       = gnt_q;
  assign bus.owner       = owner_q;
  assign bus.owner_valid = valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_pci_arbiter.sv
// Scoreboard bench for pci_arbiter (NUM_DEV=3, TIMEOUT=4); expected outputs
// are queued with each driven cycle and compared after the clock edge.
module tb_pci_arbiter;
  localparam int NUM_DEV = 3;
  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic [6:0] exp_q[$];

  pci_arb_if #(.NUM_DEV(NUM_DEV)) bus();

  pci_arbiter #(.NUM_DEV(NUM_DEV), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge.
  task automatic cyc(input string name, input logic rst, input logic [2:0] req,
                     input logic fr, input logic ir, input logic [2:0] g,
                     input logic [1:0] o, input logic v, input logic t);
    logic [6:0] e;
    reset       = rst;
    bus.req_n   = req;
    bus.frame_n = fr;
    bus.irdy_n  = ir;
    exp_q.push_back({g, o, v, t});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({name, ".gnt_n"},   32'(bus.gnt_n),       32'(e[6:4]));
    chk({name, ".owner"},   32'(bus.owner),       32'(e[3:2]));
    chk({name, ".valid"},   32'(bus.owner_valid), 32'(e[1]));
    chk({name, ".timeout"}, 32'(bus.timeout),     32'(e[0]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=time_limit want=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] one;
    logic [2:0] g;
    one = 3'b001;
    cyc("rst0", 1'b1, 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, 1'b0);
    cyc("rst0", 1'b1, 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, 1'b0);

`ifdef PCI_ARB_PARK_EN
    cyc("park_idle",  1'b0, 3'b111, 1'b1, 1'b1, 3'b110, 2'd0, 1'b0, 1'b0);
    cyc("park_hold",  1'b0, 3'b111, 1'b1, 1'b1, 3'b110, 2'd0, 1'b0, 1'b0);
    cyc("park_turn",  1'b0, 3'b011, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, 1'b0);
    cyc("park_gnt2",  1'b0, 3'b011, 1'b1, 1'b1, 3'b011, 2'd2, 1'b1, 1'b0);
    cyc("park_wd",    1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd2, 1'b0, 1'b0);
    cyc("park_on2",   1'b0, 3'b111, 1'b1, 1'b1, 3'b011, 2'd2, 1'b0, 1'b0);
    cyc("park_self",  1'b0, 3'b011, 1'b1, 1'b1, 3'b011, 2'd2, 1'b1, 1'b0);
    cyc("park_wd2",   1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd2, 1'b0, 1'b0);
    cyc("park_on2b",  1'b0, 3'b111, 1'b1, 1'b1, 3'b011, 2'd2, 1'b0, 1'b0);
    cyc("park_frame", 1'b0, 3'b111, 1'b0, 1'b0, 3'b011, 2'd2, 1'b0, 1'b0);
    cyc("park_end",   1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd2, 1'b0, 1'b0);
    cyc("park_back",  1'b0, 3'b111, 1'b1, 1'b1, 3'b011, 2'd2, 1'b0, 1'b0);
`else
    // single request, 4-cycle transaction
    cyc("s_req", 1'b0, 3'b101, 1'b1, 1'b1, 3'b101, 2'd1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc("s_busy", 1'b0, 3'b101, 1'b0, 1'b0, 3'b101, 2'd1, 1'b1, 1'b0);
    cyc("s_turn", 1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd1, 1'b0, 1'b0);
    cyc("s_idle", 1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd1, 1'b0, 1'b0);

    // round robin from a fresh pointer
    cyc("rst1", 1'b1, 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      g = ~(one << i);
      cyc("rr_gnt",  1'b0, 3'b000, 1'b1, 1'b1, g, 2'(i), 1'b1, 1'b0);
      cyc("rr_busy", 1'b0, 3'b000, 1'b0, 1'b0, g, 2'(i), 1'b1, 1'b0);
      cyc("rr_busy", 1'b0, 3'b000, 1'b0, 1'b0, g, 2'(i), 1'b1, 1'b0);
      cyc("rr_turn", 1'b0, 3'b000, 1'b1, 1'b1, 3'b111, 2'(i), 1'b0, 1'b0);
    end
    cyc("rr_wrap", 1'b0, 3'b000, 1'b1, 1'b1, 3'b110, 2'd0, 1'b1, 1'b0);
    cyc("rr_drop", 1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, 1'b0);
    cyc("rr_idle", 1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, 1'b0);

    // request withdrawn before FRAME keeps ptr at 0
    cyc("wd_gnt",  1'b0, 3'b110, 1'b1, 1'b1, 3'b110, 2'd0, 1'b1, 1'b0);
    cyc("wd_turn", 1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, 1'b0);
    cyc("wd_ptr",  1'b0, 3'b100, 1'b1, 1'b1, 3'b110, 2'd0, 1'b1, 1'b0);
    cyc("wd_drop", 1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, 1'b0);
    cyc("wd_idle", 1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, 1'b0);

    // timeout after TIMEOUT cycles without FRAME
    cyc("to_gnt", 1'b0, 3'b011, 1'b1, 1'b1, 3'b011, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++)
      cyc("to_wait", 1'b0, 3'b011, 1'b1, 1'b1, 3'b011, 2'd2, 1'b1, 1'b0);
    cyc("to_pulse", 1'b0, 3'b001, 1'b1, 1'b1, 3'b111, 2'd2, 1'b0, 1'b1);
    cyc("to_next",  1'b0, 3'b001, 1'b1, 1'b1, 3'b101, 2'd1, 1'b1, 1'b0);
    cyc("to_drop",  1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd1, 1'b0, 1'b0);
    cyc("to_idle",  1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd1, 1'b0, 1'b0);

    // reset in the middle of a transaction
    cyc("mb_gnt",   1'b0, 3'b101, 1'b1, 1'b1, 3'b101, 2'd1, 1'b1, 1'b0);
    cyc("mb_busy",  1'b0, 3'b101, 1'b0, 1'b0, 3'b101, 2'd1, 1'b1, 1'b0);
    cyc("mb_rst",   1'b1, 3'b101, 1'b0, 1'b0, 3'b111, 2'd0, 1'b0, 1'b0);
    cyc("mb_ptr",   1'b0, 3'b010, 1'b1, 1'b1, 3'b110, 2'd0, 1'b1, 1'b0);
    cyc("mb_drop",  1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, 1'b0);
    cyc("mb_idle",  1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd0, 1'b0, 1'b0);
    cyc("mb_rst2",  1'b1, 3'b111, 1'b0, 1'b0, 3'b111, 2'd0, 1'b0, 1'b0);
    cyc("mb_gnt2",  1'b0, 3'b011, 1'b1, 1'b1, 3'b011, 2'd2, 1'b1, 1'b0);
    cyc("mb_drop2", 1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd2, 1'b0, 1'b0);
    cyc("mb_idle2", 1'b0, 3'b111, 1'b1, 1'b1, 3'b111, 2'd2, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pci_arbiter.md
# pci_arbiter

Central arbiter for the shared PCI-style address/data bus: samples the active-low `req_n` lines of up to `NUM_DEV` bus devices (A=0, B=1, C=2 by default), issues a single active-low grant with round-robin fairness, and tracks the granted master through its transaction by monitoring `frame_n`/`irdy_n`. It sits at top level beside the devices. Its `gnt_n[i]` drives each device's `grant` input, and each device's `request` output drives `req_n[i]`. It guarantees one idle turnaround cycle between owners and reclaims grants from masters that never start a transaction.

## Interface
- `NUM_DEV`, 3: number of requesting devices, 2..8.
- `TIMEOUT`, 16: cycles a granted master may hold `gnt_n` without asserting `frame_n`, 2..255.
- `IDX_W`, $clog2(NUM_DEV): width of owner index.

Ports (one clock, `clk`; reset `reset` is synchronous, active-high):
- `clk` in 1: bus clock, all logic on rising edge.
- `reset` in 1: synchronous active-high reset.
- `req_n` in NUM_DEV: per-device bus request, active low.
- `frame_n` in 1: shared bus FRAME, active low.
- `irdy_n` in 1: shared bus initiator-ready, active low.
- `gnt_n` out NUM_DEV: per-device grant, active low, registered, at most one bit low.
- `owner` out IDX_W: index of current or last grantee.
- `owner_valid` out 1: high while a grant is issued due to a live request (GRANTED or BUSY).
- `timeout` out 1: one-cycle pulse when a grant is revoked for no FRAME.

## Operation
- Reset values: `gnt_n` all ones, `owner`=0, `owner_valid`=0, `timeout`=0, state IDLE, priority pointer `ptr`=0, timer=0.
- States: IDLE, GRANTED, BUSY, TURN.
- IDLE:
  - If any `req_n` bit is low, select the first requester scanning `ptr`, `ptr`+1, … modulo NUM_DEV.
  - Next cycle: `gnt_n[win]`=0, `owner`=win, `owner_valid`=1, timer=0, then GRANTED.
  - No request: all grants high (see Configuration).
- GRANTED: evaluated in priority order.
  - (1) `frame_n`==0 sampled: go to BUSY, `ptr`=(owner+1) mod NUM_DEV.
  - (2) `req_n[owner]`==1 with `frame_n` high: go to TURN, `ptr` unchanged.
  - (3) timer==TIMEOUT-1: go to TURN, `timeout`=1 for one cycle, `ptr`=(owner+1) mod NUM_DEV.
  - Otherwise timer+1. The timer saturates and never wraps.
- BUSY:
  - Grant is held.
  - When `frame_n`==1 and `irdy_n`==1 are sampled together (bus idle), go to TURN.
  - Requests from other devices are ignored until then.
- TURN:
  - Lasts exactly one cycle with all `gnt_n` high and `owner_valid`=0. Then IDLE.
  - This is the single guaranteed dead cycle between owners. A new grant appears no earlier than the cycle after TURN.
- Grant never moves directly from one device to another. The same device may be re-granted only after TURN.
- Simultaneous requests are resolved by round-robin only. Priority is fixed solely by `ptr`.
- A request arriving during BUSY or TURN is held by the device and served from IDLE.
- `reset` asserted in any state, including mid-BUSY, forces reset values on the next edge regardless of bus signals.

## Timing
- Request to grant: `req_n` low sampled at edge N → `gnt_n` low after edge N+1 (1-cycle latency from IDLE).
- End of transaction to next grant: bus idle sampled at edge M → TURN after M+1 → earliest new grant after M+2.
- Timeout: grant asserted after edge G with no FRAME → TURN after edge G+TIMEOUT, `timeout` high for that cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `PCI_ARB_PARK_EN` defined: bus parking is enabled.
  - In IDLE with no request, `gnt_n[owner]` is held low (parked on last owner; device 0 after reset), with `owner_valid`=0.
  - A parked device asserting `frame_n` without a request moves directly to BUSY.
  - A request from another device causes one TURN cycle before its grant (2-cycle latency).
  - If the parked device itself requests, it goes to GRANTED on the next edge with no TURN.
- Not defined: all `gnt_n` high in IDLE. Latency stays 1 cycle.

## Test plan
- Single request:
  - Stimulus: `req_n`=3'b101. Response: `gnt_n`=3'b101 one cycle later, `owner`=1.
  - Stimulus: FRAME low for 4 cycles, then idle. Response: TURN cycle with `gnt_n`=3'b111, then IDLE.
- Round-robin: `req_n`=3'b000 held, each granted master runs a 2-cycle transaction → grant order 0,1,2,0, with an all-ones `gnt_n` cycle between each.
- Timeout: TIMEOUT=4, `req_n[2]` low, FRAME never asserted → `gnt_n[2]` low for 4 cycles, `timeout` pulse, then device 0 or 1 wins ahead of 2 if requesting.
- Request withdrawn: device 0 granted, `req_n[0]` released before FRAME → TURN next cycle, no `timeout` pulse, `ptr` still 0.
- Reset mid-BUSY: `reset` high while `frame_n`=0 → next edge `gnt_n`=3'b111, `owner`=0, `owner_valid`=0. After release, a request from device 2 is granted in 1 cycle.
- With `PCI_ARB_PARK_EN`:
  - Idle after reset: `gnt_n`=3'b110.
  - `req_n`=3'b011: TURN, then `gnt_n`=3'b011 two cycles after the request.
